// File: rtl/spi_echo_pkg.sv
// Shared encodings for the SPI FIFO echo peripheral: transmit transform modes and engine states.
package spi_echo_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_INCR   = 2'd2,
        MODE_COUNT  = 2'd3
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    assign do_pop     = i_pop && !o_empty;
    assign do_push    = i_push && (!o_full || do_pop);
    assign o_full     = (level == (AW+1)'(DEPTH));
    assign o_empty    = (level == '0);
    assign o_level    = level;
    assign o_pop_data = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/spi_peripheral_fifo_echo.sv
// SPI mode-0 peripheral that buffers received words in a FIFO and returns them, optionally transformed.
module spi_peripheral_fifo_echo
    import spi_echo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_spi_clk,
    input  logic                          i_spi_copi,
    input  logic                          i_spi_cs_n,
    output logic                          o_spi_cipo,
    output logic                          o_spi_cipo_oe,
    input  logic [1:0]                    i_mode,
    input  logic                          i_clear_flags,
    output logic [DATA_WIDTH-1:0]         o_rx_word,
    output logic                          o_rx_dv,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic                          o_underflow,
    output logic                          o_active
);

    localparam int BW = $clog2(DATA_WIDTH);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic copi_p0, copi_p1;
    logic cs_p0, cs_p1, cs_p2;
    logic armed;
    logic sclk_rise, sclk_fall, cs_fall;

    spi_state_e            state, state_nxt;
    spi_mode_e             mode_q;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] word_cnt;
    logic                  load_pend;
    logic                  vld_p0;
    logic                  fetch;
    logic                  pop;
    logic                  underflow_set;
    logic                  overflow_set;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    function automatic logic [DATA_WIDTH-1:0] tx_transform(input spi_mode_e mode,
                                                           input logic [DATA_WIDTH-1:0] head);
        case (mode)
            MODE_INVERT: return ~head;
            MODE_INCR:   return head + 1'b1;
            default:     return head;
        endcase
    endfunction

    // Synchronisers. CS resets to "selected" so a reset mid-transaction cannot fabricate a CS fall;
    // the engine stays disarmed until CS has genuinely been seen high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            copi_p0 <= 1'b0;
            copi_p1 <= 1'b0;
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sclk_p0 <= i_spi_clk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            copi_p0 <= i_spi_copi;
            copi_p1 <= copi_p0;
            cs_p0   <= i_spi_cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            if (cs_p1) armed <= 1'b1;
        end
    end

    assign sclk_rise     = sclk_p1 && !sclk_p2;
    assign sclk_fall     = !sclk_p1 && sclk_p2;
    assign cs_fall       = armed && cs_p2 && !cs_p1;
    assign o_spi_cipo_oe = armed && !cs_p1;
    assign o_spi_cipo    = o_spi_cipo_oe && tx_shift[DATA_WIDTH-1];
    assign o_active      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        unique case (state)
            ST_IDLE:  if (cs_fall) state_nxt = ST_LOAD;
            ST_LOAD: begin
                fetch     = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: if (sclk_fall && load_pend) fetch = 1'b1;
            default:  state_nxt = ST_IDLE;
        endcase
        if (cs_p1) begin
            state_nxt = ST_IDLE;
            fetch     = 1'b0;
        end
    end

    always_comb begin
        fetch_word    = FILL_WORD;
        pop           = 1'b0;
        underflow_set = 1'b0;
        if (mode_q == MODE_COUNT) begin
            fetch_word = word_cnt;
        end else if (fifo_empty) begin
            underflow_set = fetch;
        end else begin
            fetch_word = tx_transform(mode_q, fifo_head);
            pop        = fetch;
        end
    end

    assign overflow_set = vld_p0 && fifo_full && !pop;

    // Stage p0: bit sampling; vld_p0 marks a completed word one cycle after the last rise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_ECHO;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            vld_p0    <= 1'b0;
            word_cnt  <= '0;
            rx_shift  <= '0;
        end else begin
            state  <= state_nxt;
            vld_p0 <= 1'b0;
            if (vld_p0) word_cnt <= word_cnt + 1'b1;
            if (state == ST_IDLE && state_nxt == ST_LOAD) begin
                mode_q   <= spi_mode_e'(i_mode);
                word_cnt <= '0;
            end
            if (state_nxt == ST_IDLE) begin
                bit_cnt   <= '0;
                load_pend <= 1'b0;
            end else if (state == ST_SHIFT) begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], copi_p1};
                    if (bit_cnt == BW'(DATA_WIDTH-1)) begin
                        bit_cnt   <= '0;
                        vld_p0    <= 1'b1;
                        load_pend <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (fetch) load_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_shift <= '0;
        end else if (fetch) begin
            tx_shift <= fetch_word;
        end else if (state == ST_SHIFT && sclk_fall) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Stage p1: word delivery and sticky status.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rx_word   <= '0;
            o_rx_dv     <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_rx_dv <= vld_p0;
            if (vld_p0) o_rx_word <= rx_shift;
            if (overflow_set)       o_overflow <= 1'b1;
            else if (i_clear_flags) o_overflow <= 1'b0;
            if (underflow_set)      o_underflow <= 1'b1;
            else if (i_clear_flags) o_underflow <= 1'b0;
        end
    end

    spi_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (vld_p0),
        .i_push_data (rx_shift),
        .i_pop       (pop),
        .o_pop_data  (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_level     (o_fifo_level)
    );

endmodule

// File: tb/tb_spi_peripheral_fifo_echo.sv
// Scoreboarded bench for spi_peripheral_fifo_echo: directed SPI transactions, queued expectations.
module tb_spi_peripheral_fifo_echo;

    localparam int DW   = 8;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sclk = 1'b0;
    logic          copi = 1'b0;
    logic          cs_n = 1'b1;
    logic          cipo;
    logic          cipo_oe;
    logic [1:0]    mode = 2'd0;
    logic          clear_flags = 1'b0;
    logic [DW-1:0] rx_word;
    logic          rx_dv;
    logic [2:0]    level;
    logic          overflow;
    logic          underflow;
    logic          active;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_count = 0;
    int dv_mark;

    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] exp_cipo[$];

    always #5 clk = ~clk;

    spi_peripheral_fifo_echo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .FILL_WORD  (8'h00)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_spi_clk     (sclk),
        .i_spi_copi    (copi),
        .i_spi_cs_n    (cs_n),
        .o_spi_cipo    (cipo),
        .o_spi_cipo_oe (cipo_oe),
        .i_mode        (mode),
        .i_clear_flags (clear_flags),
        .o_rx_word     (rx_word),
        .o_rx_dv       (rx_dv),
        .o_fifo_level  (level),
        .o_overflow    (overflow),
        .o_underflow   (underflow),
        .o_active      (active)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        wait_clks(1);
        clear_flags = 1'b0;
        wait_clks(1);
    endtask

    task automatic cs_begin(input logic [1:0] m);
        mode = m;
        cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    // Shifts nbits of w MSB first; the final bit of a transaction leaves SCLK high so CS rises first.
    task automatic spi_word(input logic [DW-1:0] w, input int nbits, input bit final_word);
        for (int i = 0; i < nbits; i++) begin
            copi = w[DW-1-i];
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
            if (!(final_word && i == nbits-1)) sclk = 1'b0;
        end
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        wait_clks(4);
        sclk = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic expect_word(input logic [DW-1:0] rx, input logic [DW-1:0] tx);
        exp_rx.push_back(rx);
        exp_cipo.push_back(tx);
    endtask

    initial begin
        int k;
        fork
            forever begin
                @(negedge clk);
                if (rx_dv) begin
                    dv_count++;
                    if (exp_rx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_dv_unexpected: got word %0h, expected no strobe", rx_word);
                    end else begin
                        check("rx_word", rx_word, exp_rx.pop_front());
                    end
                end
            end
            begin
                int nb = 0;
                logic [DW-1:0] sh = '0;
                forever begin
                    @(posedge sclk or posedge cs_n or negedge reset_n);
                    if (cs_n || !reset_n) begin
                        nb = 0;
                    end else begin
                        sh = {sh[DW-2:0], cipo};
                        nb++;
                        if (nb == DW) begin
                            nb = 0;
                            if (exp_cipo.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL cipo_unexpected: got word %0h, expected none", sh);
                            end else begin
                                check("cipo_word", sh, exp_cipo.pop_front());
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        wait_clks(3);
        check("reset_cipo", cipo, 0);
        check("reset_oe", cipo_oe, 0);
        check("reset_level", level, 0);
        check("reset_flags", {overflow, underflow, active, rx_dv}, 0);
        check("reset_rx_word", rx_word, 0);
        reset_n = 1'b1;
        wait_clks(6);

        // 1: echo with an empty FIFO first
        dv_mark = dv_count;
        expect_word(8'hA5, 8'h00);
        expect_word(8'h3C, 8'hA5);
        expect_word(8'h0F, 8'h3C);
        cs_begin(2'd0);
        check("active_in_xfer", active, 1);
        check("oe_in_xfer", cipo_oe, 1);
        spi_word(8'hA5, 8, 0);
        spi_word(8'h3C, 8, 0);
        spi_word(8'h0F, 8, 1);
        cs_end();
        check("t1_dv_pulses", dv_count - dv_mark, 3);
        check("t1_underflow", underflow, 1);
        check("t1_level", level, 1);
        check("t1_overflow", overflow, 0);

        // 2: invert, echo, increment with wrap
        pulse_clear();
        check("t2_underflow_cleared", underflow, 0);
        expect_word(8'h11, 8'hF0);
        cs_begin(2'd1);
        spi_word(8'h11, 8, 1);
        cs_end();
        expect_word(8'hFF, 8'h11);
        cs_begin(2'd0);
        spi_word(8'hFF, 8, 1);
        cs_end();
        expect_word(8'h00, 8'h00);
        cs_begin(2'd2);
        spi_word(8'h00, 8, 1);
        cs_end();
        check("t2_level", level, 1);
        check("t2_underflow", underflow, 0);

        // 3: count mode, fourth push overflows
        expect_word(8'hC1, 8'h00);
        expect_word(8'hC2, 8'h01);
        expect_word(8'hC3, 8'h02);
        expect_word(8'hC4, 8'h03);
        cs_begin(2'd3);
        spi_word(8'hC1, 8, 0);
        spi_word(8'hC2, 8, 0);
        spi_word(8'hC3, 8, 0);
        spi_word(8'hC4, 8, 1);
        cs_end();
        check("t3_level", level, 4);
        check("t3_overflow", overflow, 1);
        check("t3_underflow", underflow, 0);

        // 4: full FIFO drains as it refills; then a count-mode push into a full FIFO
        pulse_clear();
        check("t4_overflow_cleared", overflow, 0);
        expect_word(8'hD1, 8'h00);
        expect_word(8'hD2, 8'hC1);
        expect_word(8'hD3, 8'hC2);
        expect_word(8'hD4, 8'hC3);
        expect_word(8'h55, 8'hD1);
        cs_begin(2'd0);
        spi_word(8'hD1, 8, 0);
        spi_word(8'hD2, 8, 0);
        spi_word(8'hD3, 8, 0);
        spi_word(8'hD4, 8, 0);
        spi_word(8'h55, 8, 1);
        cs_end();
        check("t4_level_full", level, 4);
        check("t4_no_overflow", overflow, 0);
        expect_word(8'h77, 8'h00);
        cs_begin(2'd3);
        spi_word(8'h77, 8, 1);
        cs_end();
        check("t4_overflow", overflow, 1);
        check("t4_level_held", level, 4);

        // 5: partial word discarded
        pulse_clear();
        dv_mark = dv_count;
        cs_begin(2'd3);
        spi_word(8'h96, 5, 0);
        cs_n = 1'b1;
        k = 0;
        while (active && k < 8) begin
            wait_clks(1);
            k++;
        end
        check("t5_active_fall", (k <= 4) && !active, 1);
        wait_clks(HALF);
        check("t5_no_dv", dv_count - dv_mark, 0);
        check("t5_level", level, 4);
        expect_word(8'h96, 8'hD2);
        cs_begin(2'd0);
        spi_word(8'h96, 8, 1);
        cs_end();
        check("t5_level_after", level, 4);

        // 6: reset mid-word, engine waits for a fresh CS cycle
        cs_begin(2'd0);
        spi_word(8'h5A, 3, 0);
        reset_n = 1'b0;
        wait_clks(2);
        check("t6_rst_level", level, 0);
        check("t6_rst_pins", {cipo, cipo_oe}, 0);
        check("t6_rst_flags", {overflow, underflow, active, rx_dv}, 0);
        check("t6_rst_rx_word", rx_word, 0);
        reset_n = 1'b1;
        wait_clks(2);
        dv_mark = dv_count;
        exp_cipo.push_back(8'h00);
        spi_word(8'hC3, 8, 1);
        check("t6_still_idle", active, 0);
        cs_end();
        check("t6_no_dv", dv_count - dv_mark, 0);
        check("t6_level_empty", level, 0);
        expect_word(8'h3A, 8'h00);
        cs_begin(2'd0);
        spi_word(8'h3A, 8, 1);
        cs_end();
        check("t6_level_after", level, 1);
        check("t6_underflow", underflow, 1);

        wait_clks(4);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("cipo_queue_drained", exp_cipo.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
